// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle instruction sequencer for the processor datapath.
// Each instruction walks FETCH -> DECODE -> (EXEC -> MEM/WB | BRANCH) -> FETCH. The
// instruction and data memory handshakes may insert wait states, and each ack wait is
// bounded by TIMEOUT_CYC. Datapath controls are decoded from the current state, the
// opcode (Instr_i[31:26]) and the acks. Illegal_o and Timeout_Err_o are sticky until reset.
// Ports:
//   Clk_i, Reset_i (async, active-low)   clock / reset
//   Instr_i, Zero_i                      IR contents, ALU zero flag
//   Imem_Ack_i, Mem_Ack_i                memory handshake acks
//   Imem_Req_o, IR_LdEn_o                instruction fetch control
//   PC_Sel_o, PC_LdEn_o                  PC update control
//   RF_WrEn_o, RF_WrData_sel_o, RF_B_sel_o           register file control
//   ALU_Bin_sel_o, ALU_func_o, ALU_LdEn_o            ALU control
//   Mem_Req_o, Mem_WrEn_o                data memory control
//   Illegal_o, Timeout_Err_o, State_o    status / debug
module multicycle_control #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        Clk_i,
  input  logic        Reset_i,
  input  logic [31:0] Instr_i,
  input  logic        Zero_i,
  input  logic        Imem_Ack_i,
  input  logic        Mem_Ack_i,
  output logic        Imem_Req_o,
  output logic        IR_LdEn_o,
  output logic        PC_Sel_o,
  output logic        PC_LdEn_o,
  output logic        RF_WrEn_o,
  output logic        RF_WrData_sel_o,
  output logic        RF_B_sel_o,
  output logic        ALU_Bin_sel_o,
  output logic [3:0]  ALU_func_o,
  output logic        ALU_LdEn_o,
  output logic        Mem_Req_o,
  output logic        Mem_WrEn_o,
  output logic        Illegal_o,
  output logic        Timeout_Err_o,
  output logic [2:0]  State_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_BRANCH = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd7;

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_SW    = 6'b011111;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;

  logic [5:0] op;
  logic       is_alu, is_load, is_store, is_br;
  logic       dec_wd_sel, dec_b_sel, dec_bin_sel;
  logic [3:0] dec_func;
  logic       br_taken;

  logic       imem_req, ir_lden, pc_sel, pc_lden, rf_wren;
  logic       wd_sel, b_sel, bin_sel, alu_lden, mem_req, mem_wren;
  logic [3:0] alu_func;
  logic       hold_sel;

  logic       unused_instr;

  assign op           = Instr_i[31:26];
  assign unused_instr = ^Instr_i[25:4];

  // Opcode class and static datapath selects
  always_comb begin
    is_alu      = 1'b0;
    is_load     = 1'b0;
    is_store    = 1'b0;
    is_br       = 1'b0;
    dec_wd_sel  = 1'b0;
    dec_b_sel   = 1'b0;
    dec_bin_sel = 1'b0;
    dec_func    = 4'd0;
    case (op)
      OP_RTYPE: begin
        is_alu = 1'b1; dec_wd_sel = 1'b1; dec_func = Instr_i[3:0];
      end
      OP_LI, OP_ADDI: begin
        is_alu = 1'b1; dec_wd_sel = 1'b1; dec_b_sel = 1'b1; dec_bin_sel = 1'b1;
      end
      OP_ANDI: begin
        is_alu = 1'b1; dec_wd_sel = 1'b1; dec_b_sel = 1'b1; dec_bin_sel = 1'b1;
        dec_func = 4'd2;
      end
      OP_ORI: begin
        is_alu = 1'b1; dec_wd_sel = 1'b1; dec_b_sel = 1'b1; dec_bin_sel = 1'b1;
        dec_func = 4'd3;
      end
      OP_LW: begin
        is_load = 1'b1; dec_b_sel = 1'b1; dec_bin_sel = 1'b1;
      end
      OP_LB: begin
        is_load = 1'b1; dec_b_sel = 1'b1; dec_bin_sel = 1'b1; dec_func = 4'd3;
      end
      OP_SW: begin
        is_store = 1'b1; dec_b_sel = 1'b1; dec_bin_sel = 1'b1;
      end
      OP_B, OP_BEQ, OP_BNE: begin
        is_br = 1'b1; dec_b_sel = 1'b1; dec_func = 4'd1;
      end
      default: ;
    endcase
  end

  assign br_taken = (op == OP_B) | ((op == OP_BEQ) & Zero_i) | ((op == OP_BNE) & ~Zero_i);

  // Next state, wait counter, sticky flags and datapath controls
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    imem_req  = 1'b0;
    ir_lden   = 1'b0;
    pc_sel    = 1'b0;
    pc_lden   = 1'b0;
    rf_wren   = 1'b0;
    alu_lden  = 1'b0;
    mem_req   = 1'b0;
    mem_wren  = 1'b0;
    hold_sel  = 1'b0;
    wd_sel    = 1'b0;
    b_sel     = 1'b0;
    bin_sel   = 1'b0;
    alu_func  = 4'd0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (Imem_Ack_i) begin
          ir_lden = 1'b1;
          state_d = S_DECODE;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_ERROR;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        hold_sel = 1'b1;
        if (is_alu || is_load || is_store) begin
          state_d = S_EXEC;
        end else if (is_br) begin
          state_d = S_BRANCH;
        end else begin
          state_d   = S_ERROR;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        hold_sel = 1'b1;
        alu_lden = 1'b1;
        state_d  = (is_load || is_store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        hold_sel = 1'b1;
        mem_req  = 1'b1;
        mem_wren = is_store;
        if (Mem_Ack_i) begin
          // Stores retire here; loads still need the register write-back
          if (is_store) begin
            pc_lden = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_ERROR;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB: begin
        hold_sel = 1'b1;
        rf_wren  = 1'b1;
        pc_lden  = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        hold_sel = 1'b1;
        pc_lden  = 1'b1;
        pc_sel   = br_taken;
        state_d  = S_FETCH;
      end
      S_ERROR: ;
      default: state_d = S_ERROR;
    endcase

    if (hold_sel) begin
      wd_sel   = dec_wd_sel;
      b_sel    = dec_b_sel;
      bin_sel  = dec_bin_sel;
      alu_func = dec_func;
    end

    // Every state entry restarts the ack wait budget
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // State register
  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // FETCH is the reset state, so its fetch controls are masked while reset is held
  assign Imem_Req_o      = imem_req & Reset_i;
  assign IR_LdEn_o       = ir_lden & Reset_i;
  assign PC_Sel_o        = pc_sel;
  assign PC_LdEn_o       = pc_lden;
  assign RF_WrEn_o       = rf_wren;
  assign RF_WrData_sel_o = wd_sel;
  assign RF_B_sel_o      = b_sel;
  assign ALU_Bin_sel_o   = bin_sel;
  assign ALU_func_o      = alu_func;
  assign ALU_LdEn_o      = alu_lden;
  assign Mem_Req_o       = mem_req;
  assign Mem_WrEn_o      = mem_wren;
  assign Illegal_o       = illegal_q;
  assign Timeout_Err_o   = timeout_q;
  assign State_o         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table-driven and randomized checks of multicycle_control.
// Expected per-cycle control traces are generated from the instruction-level rules
// (state sequence, wait cycles, selects per opcode), then compared cycle by cycle.
module tb_multicycle_control;

  localparam int TMO = 4;

  localparam logic [5:0] OP_R    = 6'b100000;
  localparam logic [5:0] OP_LI   = 6'b111000;
  localparam logic [5:0] OP_ADDI = 6'b110000;
  localparam logic [5:0] OP_ANDI = 6'b110010;
  localparam logic [5:0] OP_ORI  = 6'b110011;
  localparam logic [5:0] OP_LW   = 6'b001111;
  localparam logic [5:0] OP_LB   = 6'b000011;
  localparam logic [5:0] OP_SW   = 6'b011111;
  localparam logic [5:0] OP_B    = 6'b111111;
  localparam logic [5:0] OP_BEQ  = 6'b000000;
  localparam logic [5:0] OP_BNE  = 6'b000001;

  logic [5:0] legal_ops [11] = '{OP_R, OP_LI, OP_ADDI, OP_ANDI, OP_ORI, OP_LW,
                                 OP_LB, OP_SW, OP_B, OP_BEQ, OP_BNE};

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] Instr = '0;
  logic        Zero = 1'b0;
  logic        Imem_Ack = 1'b0;
  logic        Mem_Ack = 1'b0;
  logic        Imem_Req, IR_LdEn, PC_Sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel;
  logic        ALU_Bin_sel, ALU_LdEn, Mem_Req, Mem_WrEn, Illegal, Timeout_Err;
  logic [3:0]  ALU_func;
  logic [2:0]  State;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  multicycle_control #(.TIMEOUT_CYC(TMO)) dut (
    .Clk_i(Clk), .Reset_i(Reset), .Instr_i(Instr), .Zero_i(Zero),
    .Imem_Ack_i(Imem_Ack), .Mem_Ack_i(Mem_Ack),
    .Imem_Req_o(Imem_Req), .IR_LdEn_o(IR_LdEn), .PC_Sel_o(PC_Sel), .PC_LdEn_o(PC_LdEn),
    .RF_WrEn_o(RF_WrEn), .RF_WrData_sel_o(RF_WrData_sel), .RF_B_sel_o(RF_B_sel),
    .ALU_Bin_sel_o(ALU_Bin_sel), .ALU_func_o(ALU_func), .ALU_LdEn_o(ALU_LdEn),
    .Mem_Req_o(Mem_Req), .Mem_WrEn_o(Mem_WrEn), .Illegal_o(Illegal),
    .Timeout_Err_o(Timeout_Err), .State_o(State)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       imem_req;
    logic       ir_ld;
    logic       pc_sel;
    logic       pc_ld;
    logic       rf_we;
    logic       wd_sel;
    logic       b_sel;
    logic       bin_sel;
    logic [3:0] func;
    logic       alu_ld;
    logic       mem_req;
    logic       mem_we;
    logic       ill;
    logic       tmo;
  } outs_t;

  typedef struct {
    logic  imem_ack;
    logic  mem_ack;
    outs_t exp;
  } cyc_t;

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    int          wi;
    int          wm;
    int          lat;
    logic        pcsel;
    int          rf;
    bit          err;
  } vec_t;

  cyc_t  q[$];
  vec_t  vt[$];
  outs_t ZO = '0;

  function automatic outs_t sample();
    outs_t s;
    s.st = State; s.imem_req = Imem_Req; s.ir_ld = IR_LdEn; s.pc_sel = PC_Sel;
    s.pc_ld = PC_LdEn; s.rf_we = RF_WrEn; s.wd_sel = RF_WrData_sel; s.b_sel = RF_B_sel;
    s.bin_sel = ALU_Bin_sel; s.func = ALU_func; s.alu_ld = ALU_LdEn; s.mem_req = Mem_Req;
    s.mem_we = Mem_WrEn; s.ill = Illegal; s.tmo = Timeout_Err;
    return s;
  endfunction

  task automatic check_outs(input string name, input int idx, input outs_t act, input outs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] instr=%h got st=%0d bits=%h, want st=%0d bits=%h",
               name, idx, Instr, act.st, act, exp.st, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input logic ia, input logic ma, input outs_t e);
    cyc_t c;
    c.imem_ack = ia; c.mem_ack = ma; c.exp = e;
    q.push_back(c);
  endfunction

  function automatic void push_err(input logic ill, input logic tmo);
    outs_t o;
    for (int i = 0; i < 3; i++) begin
      o = '0; o.st = 3'd7; o.ill = ill; o.tmo = tmo;
      push(1'b1, 1'b1, o);
    end
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [25:0] lo);
    return {op, lo};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    for (int i = 0; i < 11; i++) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Instruction-level reference: expected control trace of one instruction
  function automatic bit build(input logic [31:0] instr, input logic zero, input int wi, input int wm);
    logic [5:0] op;
    outs_t sel, o;
    bit alu, ld, st, br;
    op = instr[31:26];
    sel = '0; alu = 0; ld = 0; st = 0; br = 0;
    case (op)
      OP_R:          begin alu = 1; sel.wd_sel = 1; sel.func = instr[3:0]; end
      OP_LI, OP_ADDI: begin alu = 1; sel.wd_sel = 1; sel.b_sel = 1; sel.bin_sel = 1; end
      OP_ANDI:       begin alu = 1; sel.wd_sel = 1; sel.b_sel = 1; sel.bin_sel = 1; sel.func = 4'd2; end
      OP_ORI:        begin alu = 1; sel.wd_sel = 1; sel.b_sel = 1; sel.bin_sel = 1; sel.func = 4'd3; end
      OP_LW:         begin ld = 1; sel.b_sel = 1; sel.bin_sel = 1; end
      OP_LB:         begin ld = 1; sel.b_sel = 1; sel.bin_sel = 1; sel.func = 4'd3; end
      OP_SW:         begin st = 1; sel.b_sel = 1; sel.bin_sel = 1; end
      OP_B, OP_BEQ, OP_BNE: begin br = 1; sel.b_sel = 1; sel.func = 4'd1; end
      default: ;
    endcase
    for (int k = 0; k < 64; k++) begin
      o = '0; o.st = 3'd0; o.imem_req = 1;
      if (k == wi) begin
        o.ir_ld = 1; push(1'b1, rb(), o);
        break;
      end
      push(1'b0, rb(), o);
      if (k == TMO - 1) begin push_err(1'b0, 1'b1); return 1'b1; end
    end
    o = sel; o.st = 3'd1; push(rb(), rb(), o);
    if (!(alu || ld || st || br)) begin push_err(1'b1, 1'b0); return 1'b1; end
    if (br) begin
      o = sel; o.st = 3'd5; o.pc_ld = 1;
      o.pc_sel = (op == OP_B) || (op == OP_BEQ && zero) || (op == OP_BNE && !zero);
      push(rb(), rb(), o);
      return 1'b0;
    end
    o = sel; o.st = 3'd2; o.alu_ld = 1; push(rb(), rb(), o);
    if (ld || st) begin
      for (int k = 0; k < 64; k++) begin
        o = sel; o.st = 3'd3; o.mem_req = 1; o.mem_we = st;
        if (k == wm) begin
          o.pc_ld = st; push(rb(), 1'b1, o);
          if (st) return 1'b0;
          break;
        end
        push(rb(), 1'b0, o);
        if (k == TMO - 1) begin push_err(1'b0, 1'b1); return 1'b1; end
      end
    end
    o = sel; o.st = 3'd4; o.rf_we = 1; o.pc_ld = 1; push(rb(), rb(), o);
    return 1'b0;
  endfunction

  int pc_cnt, pc_idx, rf_cnt, err_idx;
  logic pc_sel_seen;

  // Apply queued cycles: inputs driven just after posedge, outputs sampled at negedge
  task automatic play(input int n_max);
    outs_t a;
    int n;
    pc_cnt = 0; pc_idx = -1; pc_sel_seen = 1'b0; rf_cnt = 0; err_idx = -1;
    n = (n_max < q.size()) ? n_max : q.size();
    for (int i = 0; i < n; i++) begin
      Imem_Ack = q[i].imem_ack;
      Mem_Ack  = q[i].mem_ack;
      @(negedge Clk);
      a = sample();
      check_outs("cyc", i, a, q[i].exp);
      if (a.pc_ld) begin pc_cnt++; pc_idx = i; pc_sel_seen = a.pc_sel; end
      if (a.rf_we) rf_cnt++;
      if (a.st == 3'd7 && err_idx < 0) err_idx = i;
      @(posedge Clk); #1;
    end
    q.delete();
  endtask

  task automatic reset_pulse();
    Reset = 1'b0; Imem_Ack = 1'b1; Mem_Ack = 1'b1;
    #2;
    check_outs("reset", 0, sample(), ZO);
    @(posedge Clk); #1;
    check_outs("reset_hold", 0, sample(), ZO);
    Reset = 1'b1;
  endtask

  function automatic void add_vec(input logic [31:0] instr, input logic zero, input int wi,
                                  input int wm, input int lat, input logic pcsel, input int rf,
                                  input bit err);
    vec_t v;
    v.instr = instr; v.zero = zero; v.wi = wi; v.wm = wm; v.lat = lat;
    v.pcsel = pcsel; v.rf = rf; v.err = err;
    vt.push_back(v);
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    bit err;
    outs_t a;
    logic [31:0] r;
    logic [5:0] op;
    int wi, wm;

    //      instr                          zero wi   wm   lat pcsel rf err
    add_vec(mk(OP_ADDI, 26'h0012345),      0,   0,   0,   4,  0,    1, 0);
    add_vec(mk(OP_LW,   26'h0000040),      0,   0,   3,   8,  0,    1, 0);
    add_vec(mk(OP_BEQ,  26'h0000010),      1,   0,   0,   3,  1,    0, 0);
    add_vec(mk(OP_BEQ,  26'h0000010),      0,   0,   0,   3,  0,    0, 0);
    add_vec(mk(OP_BNE,  26'h0000020),      1,   0,   0,   3,  0,    0, 0);
    add_vec(mk(OP_BNE,  26'h0000020),      0,   0,   0,   3,  1,    0, 0);
    add_vec(mk(OP_B,    26'h3FFFFFF),      0,   0,   0,   3,  1,    0, 0);
    add_vec(mk(OP_SW,   26'h0000008),      0,   0,   0,   4,  0,    0, 0);
    add_vec(mk(OP_R,    26'h0A5A5A5),      0,   2,   0,   6,  0,    1, 0);
    add_vec(mk(OP_LB,   26'h0000003),      0,   1,   1,   7,  0,    1, 0);
    add_vec(mk(OP_LI,   26'h000FFFF),      0,   TMO-1, 0, 7,  0,    1, 0);
    add_vec(mk(OP_ANDI, 26'h00000F0),      0,   0,   0,   4,  0,    1, 0);
    add_vec(mk(OP_ORI,  26'h000000F),      0,   0,   0,   4,  0,    1, 0);
    add_vec(mk(OP_SW,   26'h0000100),      0,   0,   2,   6,  0,    0, 0);
    add_vec(mk(OP_BNE,  26'h0000000),      0,   1,   0,   4,  1,    0, 0);
    add_vec(mk(6'b101010, 26'h0000000),    0,   0,   0,   2,  0,    0, 1);
    add_vec(mk(OP_ADDI, 26'h0000001),      0,   TMO, 0,   4,  0,    0, 1);
    add_vec(mk(OP_LW,   26'h0000004),      0,   0,   TMO, 7,  0,    0, 1);

    Reset = 1'b0; Imem_Ack = 1'b1; Mem_Ack = 1'b1;
    #3;
    check_outs("reset_init", 0, sample(), ZO);
    @(posedge Clk); #1;
    Reset = 1'b1;

    foreach (vt[i]) begin
      Instr = vt[i].instr; Zero = vt[i].zero;
      err = build(vt[i].instr, vt[i].zero, vt[i].wi, vt[i].wm);
      play(1000);
      if (vt[i].err) begin
        check_int($sformatf("v%0d_pc_cnt", i), pc_cnt, 0);
        check_int($sformatf("v%0d_err_idx", i), err_idx, vt[i].lat);
      end else begin
        check_int($sformatf("v%0d_pc_cnt", i), pc_cnt, 1);
        check_int($sformatf("v%0d_latency", i), pc_idx + 1, vt[i].lat);
        check_int($sformatf("v%0d_pc_sel", i), int'(pc_sel_seen), int'(vt[i].pcsel));
        check_int($sformatf("v%0d_rf_cnt", i), rf_cnt, vt[i].rf);
      end
      if (err) reset_pulse();
    end

    // Reset in the middle of a store's MEM phase aborts the access immediately
    Instr = mk(OP_SW, 26'h0000044); Zero = 1'b0;
    err = build(Instr, 1'b0, 0, 3);
    play(4);
    Imem_Ack = 1'b0; Mem_Ack = 1'b0;
    #1;
    a = sample();
    check_int("sw_mem_active", int'({a.mem_req, a.mem_we}), 3);
    #1 Reset = 1'b0;
    #1;
    check_outs("sw_abort", 0, sample(), ZO);
    Mem_Ack = 1'b1;
    @(posedge Clk); #1;
    check_outs("sw_abort_edge", 0, sample(), ZO);
    Reset = 1'b1;
    Instr = mk(OP_ADDI, 26'h0000077);
    err = build(Instr, 1'b0, 0, 0);
    play(1000);
    check_int("restart_latency", pc_idx + 1, 4);

    // Random instruction stream against the trace reference
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = 6'($urandom_range(0, 63)); while (is_legal(op));
      end else begin
        op = legal_ops[$urandom_range(0, 10)];
      end
      r = $urandom();
      Instr = {op, r[25:0]};
      Zero = rb();
      wi = ($urandom_range(0, 11) == 0) ? TMO : $urandom_range(0, TMO - 1);
      wm = ($urandom_range(0, 11) == 0) ? TMO : $urandom_range(0, TMO - 1);
      err = build(Instr, Zero, wi, wm);
      play(1000);
      check_int($sformatf("rnd%0d_pc_cnt", n), pc_cnt, err ? 0 : 1);
      if (err) reset_pulse();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
